time_set_ctrl: RTL

Timekeeping and time-setting controller for the wall-clock design. It consumes single-cycle pulses from the button debouncers plus a 1 Hz tick, and sequences the clock between running and hour/minute editing. It owns the hours/minutes/seconds registers that drive the display path. A held increment button generates auto-repeat increments.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/auto_repeat.sv | 42 ++++
 rtl/time_set_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the wall-clock timekeeping path.
// Wrap helpers keep out-of-range values recoverable: anything at or above the max goes to 0.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;

    localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MINUTES_MAX = 6'd59;
    localparam logic [MIN_SEC_W-1:0] SECONDS_MAX = 6'd59;

    function automatic logic [MIN_SEC_W-1:0] inc_min_sec(
        input logic [MIN_SEC_W-1:0] v,
        input logic [MIN_SEC_W-1:0] max_v
    );
        return (v >= max_v) ? '0 : v + {{(MIN_SEC_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [HOURS_W-1:0] inc_hours(input logic [HOURS_W-1:0] v);
        return (v >= HOURS_MAX) ? '0 : v + {{(HOURS_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/auto_repeat.sv
// Hold-to-repeat generator: first pulse after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
// repeat_pulse is combinational from the counter so the increment lands on the same edge that hits the count.
module auto_repeat #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic level,
    output logic repeat_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             repeating_q;
    logic             active;
    logic             hit;

    assign active       = enable & level;
    assign hit          = active & (cnt_q == (repeating_q ? PERIOD_LAST : DELAY_LAST));
    assign repeat_pulse = hit;

    // After the first fire the counter restarts from 0 against the shorter period.
    always_ff @(posedge clock) begin
        if (!reset || !active) begin
            cnt_q       <= '0;
            repeating_q <= 1'b0;
        end else if (hit) begin
            cnt_q       <= '0;
            repeating_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Wall-clock run/set controller: owns h:m:s, the edit FSM, blink phase and the auto-repeat hookup.
// edit_field is the raw FSM state, so it doubles as the state observation point.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick_1hz,
    input  logic                 mode_pulse,
    input  logic                 inc_pulse,
    input  logic                 inc_level,
    output logic [HOURS_W-1:0]   hours,
    output logic [MIN_SEC_W-1:0] minutes,
    output logic [MIN_SEC_W-1:0] seconds,
    output logic [1:0]           edit_field,
    output logic                 blink
);

    state_t                 state_q;
    logic [HOURS_W-1:0]     hours_q;
    logic [MIN_SEC_W-1:0]   minutes_q;
    logic [MIN_SEC_W-1:0]   seconds_q;
    logic                   blink_q;

    logic                   repeat_pulse;
    logic                   repeat_enable;
    logic                   inc_any;
    logic [HOURS_W-1:0]     hours_inc;
    logic [MIN_SEC_W-1:0]   minutes_inc;
    logic [MIN_SEC_W-1:0]   seconds_inc;

    // A mode press in a SET state is a state change, so it also clears the hold counter.
    assign repeat_enable = (state_q != RUN) && !mode_pulse;
    assign inc_any       = inc_pulse | repeat_pulse;

    assign hours_inc   = inc_hours(hours_q);
    assign minutes_inc = inc_min_sec(minutes_q, MINUTES_MAX);
    assign seconds_inc = inc_min_sec(seconds_q, SECONDS_MAX);

    auto_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_auto_repeat (
        .clock       (clock),
        .reset       (reset),
        .enable      (repeat_enable),
        .level       (inc_level),
        .repeat_pulse(repeat_pulse)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            blink_q   <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    blink_q <= 1'b1;
                    // The tick is honoured even when mode leaves RUN on the same edge.
                    if (tick_1hz) begin
                        seconds_q <= seconds_inc;
                        if (seconds_q >= SECONDS_MAX) begin
                            minutes_q <= minutes_inc;
                            if (minutes_q >= MINUTES_MAX) begin
                                hours_q <= hours_inc;
                            end
                        end
                    end
                    if (mode_pulse) begin
                        state_q <= SET_HOUR;
                    end
                end
                SET_HOUR: begin
                    if (mode_pulse) begin
                        state_q <= SET_MIN;
                        blink_q <= 1'b1;
                    end else begin
                        if (inc_any) begin
                            hours_q <= hours_inc;
                        end
                        if (tick_1hz) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                SET_MIN: begin
                    if (mode_pulse) begin
                        state_q   <= RUN;
                        seconds_q <= '0;
                        blink_q   <= 1'b1;
                    end else begin
                        if (inc_any) begin
                            minutes_q <= minutes_inc;
                        end
                        if (tick_1hz) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    blink_q <= 1'b1;
                end
            endcase
        end
    end

    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule
